spi_bridge_master: RTL and testbench
====================================

// Module: spi_bridge_master
// PURPOSE
// FPGA-side SPI master for the SPI-to-Avalon byte-stream bridge (spislave for spichain) protocol.
// - Drives SCK/NSS/MOSI and samples MISO; SPI mode 0, MSB first.
// - Applies the bridge's physical-layer framing on transmit: 0x4A idle, 0x4D escape.
// - Strips that framing on receive.
// - Lets on-chip logic (e.g. an NINA/ESP32 link) talk to an Avalon SPI slave bridge as the master.
// PARAMETERS
// CLK_DIV  4  SCK half-period in iCLK cycles (>=2); bit time = 2*CLK_DIV
// CS_GAP   8  minimum iCLK cycles NSS stays high between transactions (>=1)
// PORTS
// iCLK       in   1  system clock
// iRESETn    in   1  asynchronous active-low reset
// iTX_DATA   in   8  payload byte to send
// iTX_VALID  in   1  iTX_DATA valid
// oTX_READY  out  1  1-cycle pulse: iTX_DATA accepted this cycle
// iPOLL      in   1  keep NSS low and clock idle bytes (0x4A) to collect slave response
// oRX_DATA   out  8  decoded received byte
// oRX_VALID  out  1  1-cycle strobe for oRX_DATA; no backpressure
// oBUSY      out  1  high whenever state != IDLE
// oSCK       out  1  SPI clock, idles low
// oNSS       out  1  slave select, active low
// oMOSI      out  1  master out
// iMISO      in   1  master in; synchronised with 2 flops before use
// BEHAVIOUR
// - Reset (async, any state): oSCK=0, oNSS=1, oMOSI=0, oTX_READY=0, oRX_VALID=0, oRX_DATA=0, oBUSY=0.
//   Escape flags cleared, FSM->IDLE. Partial byte discarded, nothing emitted.
// - FSM: IDLE -> SETUP -> SHIFT -> NEXT -> (SHIFT | HOLD) -> GAP -> IDLE.
// - IDLE: when iTX_VALID|iPOLL, drive oNSS=0 and go to SETUP.
// - SETUP: wait CLK_DIV cycles, then byte load, then SHIFT.
// - Byte load priority:
//   (1) pending escaped byte;
//   (2) iTX_VALID: pulse oTX_READY; if byte is 0x4A or 0x4D, send 0x4D now and hold byte^0x20 pending;
//   (3) iPOLL: send 0x4A;
//   else no load.
// - SHIFT, per bit:
//   - MOSI presented with SCK low; SCK rises after CLK_DIV cycles.
//   - MISO sampled (synced) on the rising edge.
//   - SCK falls after another CLK_DIV cycles, then next bit.
//   - 8 bits = 16*CLK_DIV cycles.
// - NEXT (1 cycle): decode received byte, then attempt byte load.
//   - Load succeeds -> SHIFT with no extra gap.
//   - Otherwise -> HOLD (CLK_DIV cycles, SCK low), then oNSS=1, GAP.
// - A pending escaped byte always completes before NSS rises; iTX_VALID/iPOLL cannot shorten it.
// - GAP: CS_GAP cycles with oNSS=1, then IDLE. Requests made during GAP wait.
// - RX decode, in NEXT:
//   - 0x4A: dropped.
//   - 0x4D: sets rx_esc, no output.
//   - Any other byte b: oRX_DATA = rx_esc ? b^0x20 : b, oRX_VALID=1 for 1 cycle, rx_esc cleared.
//   - 0x4D while rx_esc=1: treated as data 0x6D.
//   - rx_esc cleared when NSS deasserts (escape never spans transactions).
// - oTX_READY is never high outside a byte load; iTX_DATA may change any cycle it is not accepted.
// - Simultaneous iTX_VALID and iPOLL: TX data wins; poll only fills gaps.
// - Latency: accept in IDLE -> first SCK rise = 2*CLK_DIV+1 cycles;
//   last SCK fall -> oRX_VALID = 1 cycle (NEXT).
// CONFIGURATION
// SPI_LOOPBACK_EN: when defined, the shift register samples oMOSI internally instead of synced iMISO.
//   - iMISO is ignored; all other timing unchanged.
//   - Used for board self-test.
// Undefined (default): iMISO through 2-flop sync is the only receive source.
// TESTING
// 1 Reset mid-byte (iRESETn low during bit 3) -> oNSS=1, oSCK=0 within same cycle, no oRX_VALID after release.
// 2 TX 0x12 then 0x34, iPOLL=0, CLK_DIV=4 -> MOSI 0x12,0x34 back-to-back.
//   - One NSS low window; 64 SCK-high cycles; oTX_READY 2 pulses; NSS high >=8 cycles after.
// 3 TX 0x4A, then 0x4D -> MOSI 0x4D,0x6A,0x4D,0x6D; oTX_READY pulses only at 1st and 3rd byte loads.
// 4 iPOLL=1, no TX, slave MISO bytes 0x4A,0x4D,0x5A,0x33 -> oRX_VALID twice: 0x7A then 0x33.
// 5 MISO 0x4D as last byte of a transaction, next transaction MISO 0x21 -> output 0x21 (rx_esc cleared).
// 6 SPI_LOOPBACK_EN defined, TX 0x4A,0x99,0x4D -> oRX_DATA 0x4A,0x99,0x4D in order.

Source files
------------

// File: rtl/spi_bridge_master.sv
// spi_bridge_master
// FPGA-side SPI master (mode 0, MSB first) for the SPI-to-Avalon byte-stream
// bridge. Transmit bytes are framed with the bridge's physical layer (0x4A is
// the idle fill, 0x4D escapes the next byte which is sent XOR 0x20), and the
// same framing is stripped from the bytes shifted in on MISO.
// Parameters: CLK_DIV is the SCK half-period in iCLK cycles (>=2), CS_GAP is
// the minimum number of iCLK cycles NSS stays high between transactions (>=1).
// Build option: define SPI_LOOPBACK_EN to feed the receive shifter from the
// master's own MOSI instead of the synchronised iMISO (board self-test).
module spi_bridge_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic [7:0] iTX_DATA,
    input  logic       iTX_VALID,
    output logic       oTX_READY,
    input  logic       iPOLL,
    output logic [7:0] oRX_DATA,
    output logic       oRX_VALID,
    output logic       oBUSY,
    output logic       oSCK,
    output logic       oNSS,
    output logic       oMOSI,
    input  logic       iMISO
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    localparam logic [7:0] IDLE_BYTE = 8'h4A;
    localparam logic [7:0] ESC_BYTE  = 8'h4D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_NEXT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             sck_q, sck_d;
    logic             nss_q, nss_d;
    logic             mosi_q, mosi_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic             esc_pend_q, esc_pend_d;
    logic [7:0]       esc_byte_q, esc_byte_d;
    logic             rx_esc_q, rx_esc_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             miso_s1_q, miso_s2_q;

    logic             load_now;
    logic             load_ok;
    logic             load_ack;
    logic             load_esc;
    logic [7:0]       load_byte;
    logic [7:0]       load_esc_byte;
    logic             start_byte;
    logic             rx_bit;

    // Two-flop synchroniser for the asynchronous MISO line
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= iMISO;
            miso_s2_q <= miso_s1_q;
        end
    end

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_s2_q;
    assign rx_bit      = mosi_q;
`else
    assign rx_bit      = miso_s2_q;
`endif

    // A byte load is attempted at the end of SETUP and in every NEXT cycle
    assign load_now = ((state_q == ST_SETUP) && (cnt_q == DIV_LAST)) ||
                      (state_q == ST_NEXT);

    // Choose the next byte to shift: pending escaped byte, then TX data, then poll fill
    always_comb begin
        load_ok       = 1'b0;
        load_ack      = 1'b0;
        load_esc      = 1'b0;
        load_byte     = IDLE_BYTE;
        load_esc_byte = iTX_DATA ^ ESC_XOR;
        if (esc_pend_q) begin
            load_ok   = 1'b1;
            load_byte = esc_byte_q;
        end else if (iTX_VALID) begin
            load_ok  = 1'b1;
            load_ack = 1'b1;
            if ((iTX_DATA == IDLE_BYTE) || (iTX_DATA == ESC_BYTE)) begin
                load_byte = ESC_BYTE;
                load_esc  = 1'b1;
            end else begin
                load_byte = iTX_DATA;
            end
        end else if (iPOLL) begin
            load_ok   = 1'b1;
            load_byte = IDLE_BYTE;
        end
    end

    // Next-state and datapath logic for the transaction sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        nss_d      = nss_q;
        mosi_d     = mosi_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        esc_pend_d = esc_pend_q;
        esc_byte_d = esc_byte_q;
        rx_esc_d   = rx_esc_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        start_byte = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iTX_VALID || iPOLL) begin
                    nss_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    if (load_ok) begin
                        start_byte = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], rx_bit};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d = ST_NEXT;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            mosi_d  = tx_sr_q[7];
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end
            end

            ST_NEXT: begin
                if (rx_sr_q == IDLE_BYTE) begin
                    rx_esc_d = rx_esc_q;
                end else if ((rx_sr_q == ESC_BYTE) && !rx_esc_q) begin
                    rx_esc_d = 1'b1;
                end else begin
                    rx_data_d  = rx_esc_q ? (rx_sr_q ^ ESC_XOR) : rx_sr_q;
                    rx_valid_d = 1'b1;
                    rx_esc_d   = 1'b0;
                end
                if (load_ok) begin
                    start_byte = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d    = '0;
                    nss_d    = 1'b1;
                    mosi_d   = 1'b0;
                    rx_esc_d = 1'b0;
                    state_d  = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_byte) begin
            mosi_d     = load_byte[7];
            tx_sr_d    = {load_byte[6:0], 1'b0};
            esc_pend_d = load_esc;
            esc_byte_d = load_esc ? load_esc_byte : esc_byte_q;
            bit_d      = 3'd0;
            cnt_d      = '0;
            state_d    = ST_SHIFT;
        end
    end

    // State and datapath registers; reset parks the bus idle and drops any partial byte
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            sck_q      <= 1'b0;
            nss_q      <= 1'b1;
            mosi_q     <= 1'b0;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            esc_pend_q <= 1'b0;
            esc_byte_q <= 8'h00;
            rx_esc_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            nss_q      <= nss_d;
            mosi_q     <= mosi_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            esc_pend_q <= esc_pend_d;
            esc_byte_q <= esc_byte_d;
            rx_esc_q   <= rx_esc_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign oTX_READY = load_now & load_ack;
    assign oRX_DATA  = rx_data_q;
    assign oRX_VALID = rx_valid_q;
    assign oBUSY     = (state_q != ST_IDLE);
    assign oSCK      = sck_q;
    assign oNSS      = nss_q;
    assign oMOSI     = mosi_q;

endmodule

// File: tb/tb_spi_bridge_master.sv
// Testbench for spi_bridge_master: a mode-0 slave model feeds MISO bytes and
// captures MOSI bytes; expected MOSI and RX bytes are queued when stimulus is
// applied and compared as the DUT produces them.
module tb_spi_bridge_master;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 8;

    logic       iCLK      = 1'b0;
    logic       iRESETn   = 1'b1;
    logic [7:0] iTX_DATA  = 8'h00;
    logic       iTX_VALID = 1'b0;
    logic       iPOLL     = 1'b0;
    logic       iMISO     = 1'b0;
    logic       oTX_READY;
    logic [7:0] oRX_DATA;
    logic       oRX_VALID;
    logic       oBUSY;
    logic       oSCK;
    logic       oNSS;
    logic       oMOSI;

    spi_bridge_master #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .iCLK      (iCLK),
        .iRESETn   (iRESETn),
        .iTX_DATA  (iTX_DATA),
        .iTX_VALID (iTX_VALID),
        .oTX_READY (oTX_READY),
        .iPOLL     (iPOLL),
        .oRX_DATA  (oRX_DATA),
        .oRX_VALID (oRX_VALID),
        .oBUSY     (oBUSY),
        .oSCK      (oSCK),
        .oNSS      (oNSS),
        .oMOSI     (oMOSI),
        .iMISO     (iMISO)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rx[$];
    logic [7:0] miso_bytes[$];

    int         sck_high_cnt   = 0;
    int         ready_cnt      = 0;
    int         nss_fall_cnt   = 0;
    int         rx_cnt         = 0;
    int         mosi_cnt       = 0;
    int         nss_high_run   = 0;
    int         last_gap       = 0;
    int         first_rise_cyc = -1;
    int         last_fall_cyc  = 0;
    int         slv_bits       = 0;
    int         slv_obits      = 0;
    logic [7:0] slv_in         = 8'h00;
    logic [7:0] slv_out        = 8'h4A;
    logic [7:0] mon_exp        = 8'h00;
    logic       prev_nss       = 1'b1;
    logic       prev_sck       = 1'b0;

    int t0, s_sck, s_rdy, s_fall, s_mosi, s_rx;
    int wait_cnt;

    always @(posedge iCLK) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one TX byte and hold it until the DUT accepts it
    task automatic applyStimulus(input logic [7:0] data);
        logic seen;
        seen      = 1'b0;
        iTX_DATA  = data;
        iTX_VALID = 1'b1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge iCLK);
            if (oTX_READY === 1'b1) seen = 1'b1;
        end
        checkOutput("tx_accept", 32'(seen), 32'd1);
        @(posedge iCLK);
        #1;
        iTX_VALID = 1'b0;
        iTX_DATA  = 8'h00;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 3000; i++) begin
            @(posedge iCLK);
            #1;
            if (oBUSY === 1'b0) break;
        end
        checkOutput("wait_idle", 32'(oBUSY), 32'd0);
    endtask

    task automatic waitNssHigh();
        for (int i = 0; i < 3000; i++) begin
            @(posedge iCLK);
            #1;
            if (oNSS === 1'b1) break;
        end
        checkOutput("wait_nss_high", 32'(oNSS), 32'd1);
    endtask

    // Mode-0 slave model and output scoreboard, sampled away from the active edge
    always @(negedge iCLK) begin
        if (oNSS === 1'b1) begin
            nss_high_run = nss_high_run + 1;
            slv_bits     = 0;
            slv_obits    = 0;
        end else begin
            if (prev_nss === 1'b1) begin
                nss_fall_cnt = nss_fall_cnt + 1;
                last_gap     = nss_high_run;
                nss_high_run = 0;
                if (miso_bytes.size() > 0) slv_out = miso_bytes.pop_front();
                else slv_out = 8'h4A;
                iMISO = slv_out[7];
            end
            if (oSCK === 1'b1 && prev_sck === 1'b0) begin
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
                slv_in   = {slv_in[6:0], oMOSI};
                slv_bits = slv_bits + 1;
                if (slv_bits == 8) begin
                    slv_bits = 0;
                    mosi_cnt = mosi_cnt + 1;
                    if (exp_mosi.size() > 0) mon_exp = exp_mosi.pop_front();
                    else mon_exp = 8'h4A;
                    checkOutput("mosi_byte", 32'(slv_in), 32'(mon_exp));
                end
            end
            if (oSCK === 1'b0 && prev_sck === 1'b1) begin
                last_fall_cyc = cyc;
                slv_obits     = slv_obits + 1;
                if (slv_obits == 8) begin
                    slv_obits = 0;
                    if (miso_bytes.size() > 0) slv_out = miso_bytes.pop_front();
                    else slv_out = 8'h4A;
                end else begin
                    slv_out = {slv_out[6:0], 1'b0};
                end
                iMISO = slv_out[7];
            end
        end
        if (oSCK === 1'b1) sck_high_cnt = sck_high_cnt + 1;
        if (oTX_READY === 1'b1) ready_cnt = ready_cnt + 1;
        if (oRX_VALID === 1'b1) begin
            rx_cnt = rx_cnt + 1;
            checkOutput("rx_latency", 32'(cyc - last_fall_cyc), 32'd1);
            checkOutput("rx_expected", 32'(exp_rx.size() > 0), 32'd1);
            if (exp_rx.size() > 0) begin
                mon_exp = exp_rx.pop_front();
                checkOutput("rx_data", 32'(oRX_DATA), 32'(mon_exp));
            end
        end
        prev_nss = oNSS;
        prev_sck = oSCK;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values, checked while reset is asserted
        #2;
        iRESETn = 1'b0;
        #1;
        checkOutput("reset_sck", 32'(oSCK), 32'd0);
        checkOutput("reset_nss", 32'(oNSS), 32'd1);
        checkOutput("reset_mosi", 32'(oMOSI), 32'd0);
        checkOutput("reset_tx_ready", 32'(oTX_READY), 32'd0);
        checkOutput("reset_rx_valid", 32'(oRX_VALID), 32'd0);
        checkOutput("reset_rx_data", 32'(oRX_DATA), 32'd0);
        checkOutput("reset_busy", 32'(oBUSY), 32'd0);
        repeat (3) @(posedge iCLK);
        #1;
        iRESETn = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;

        // Reset in the middle of bit 3 aborts the byte with no RX output
        $display("[TB] reset mid-byte");
        s_rx = rx_cnt;
        miso_bytes.push_back(8'h33);
        applyStimulus(8'hA5);
        for (wait_cnt = 0; wait_cnt < 3000; wait_cnt++) begin
            @(negedge iCLK);
            if (slv_bits == 4 && oSCK === 1'b1) break;
        end
        checkOutput("reach_bit3", 32'(slv_bits), 32'd4);
        iRESETn = 1'b0;
        #1;
        checkOutput("midreset_nss", 32'(oNSS), 32'd1);
        checkOutput("midreset_sck", 32'(oSCK), 32'd0);
        checkOutput("midreset_busy", 32'(oBUSY), 32'd0);
        repeat (2) @(posedge iCLK);
        #1;
        iRESETn = 1'b1;
        repeat (200) @(posedge iCLK);
        #1;
        checkOutput("midreset_no_rx", 32'(rx_cnt - s_rx), 32'd0);
        checkOutput("midreset_nss_stays", 32'(oNSS), 32'd1);
        miso_bytes.delete();

        // Two back-to-back bytes in one NSS window
        $display("[TB] tx 0x12 0x34");
        waitIdle();
        exp_mosi.push_back(8'h12);
        exp_mosi.push_back(8'h34);
`ifdef SPI_LOOPBACK_EN
        exp_rx.push_back(8'h12);
        exp_rx.push_back(8'h34);
`endif
        s_sck = sck_high_cnt; s_rdy = ready_cnt; s_fall = nss_fall_cnt; s_mosi = mosi_cnt;
        first_rise_cyc = -1;
        t0 = cyc;
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        waitNssHigh();
        checkOutput("latency_first_rise", 32'(first_rise_cyc - t0), 32'(2 * CLK_DIV + 1));
        checkOutput("sck_high_cycles", 32'(sck_high_cnt - s_sck), 32'(16 * CLK_DIV));
        checkOutput("tx_ready_pulses", 32'(ready_cnt - s_rdy), 32'd2);
        checkOutput("nss_windows", 32'(nss_fall_cnt - s_fall), 32'd1);
        checkOutput("mosi_bytes", 32'(mosi_cnt - s_mosi), 32'd2);

        // Escaped bytes; request is raised during the gap and must wait it out
        $display("[TB] tx 0x4A 0x4D escaped");
        exp_mosi.push_back(8'h4D);
        exp_mosi.push_back(8'h6A);
        exp_mosi.push_back(8'h4D);
        exp_mosi.push_back(8'h6D);
`ifdef SPI_LOOPBACK_EN
        exp_rx.push_back(8'h4A);
        exp_rx.push_back(8'h4D);
`endif
        s_rdy = ready_cnt; s_mosi = mosi_cnt;
        applyStimulus(8'h4A);
        checkOutput("nss_gap_min", 32'(last_gap >= CS_GAP), 32'd1);
        applyStimulus(8'h4D);
        waitNssHigh();
        checkOutput("esc_ready_pulses", 32'(ready_cnt - s_rdy), 32'd2);
        checkOutput("esc_mosi_bytes", 32'(mosi_cnt - s_mosi), 32'd4);
        checkOutput("esc_queue_empty", 32'(exp_mosi.size()), 32'd0);

`ifndef SPI_LOOPBACK_EN
        // Polling collects slave bytes and strips the framing
        $display("[TB] poll rx decode");
        waitIdle();
        s_rx = rx_cnt;
        miso_bytes.push_back(8'h4A);
        miso_bytes.push_back(8'h4D);
        miso_bytes.push_back(8'h5A);
        miso_bytes.push_back(8'h33);
        exp_rx.push_back(8'h7A);
        exp_rx.push_back(8'h33);
        iPOLL = 1'b1;
        for (wait_cnt = 0; wait_cnt < 3000; wait_cnt++) begin
            @(posedge iCLK);
            #1;
            if (exp_rx.size() == 0) break;
        end
        checkOutput("poll_rx_done", 32'(exp_rx.size()), 32'd0);
        iPOLL = 1'b0;
        waitIdle();
        checkOutput("poll_rx_count", 32'(rx_cnt - s_rx), 32'd2);

        // Escape received as the last byte does not leak into the next transaction
        $display("[TB] rx escape cleared between transactions");
        s_rx = rx_cnt;
        miso_bytes.push_back(8'h4D);
        exp_mosi.push_back(8'h11);
        applyStimulus(8'h11);
        waitIdle();
        checkOutput("esc_tail_no_rx", 32'(rx_cnt - s_rx), 32'd0);
        miso_bytes.push_back(8'h21);
        exp_mosi.push_back(8'h22);
        exp_rx.push_back(8'h21);
        applyStimulus(8'h22);
        waitIdle();
        checkOutput("esc_cleared_rx_count", 32'(rx_cnt - s_rx), 32'd1);
`else
        // Loopback self-test: transmitted bytes come back decoded
        $display("[TB] loopback tx 0x4A 0x99 0x4D");
        waitIdle();
        s_rx = rx_cnt;
        exp_mosi.push_back(8'h4D);
        exp_mosi.push_back(8'h6A);
        exp_mosi.push_back(8'h99);
        exp_mosi.push_back(8'h4D);
        exp_mosi.push_back(8'h6D);
        exp_rx.push_back(8'h4A);
        exp_rx.push_back(8'h99);
        exp_rx.push_back(8'h4D);
        applyStimulus(8'h4A);
        applyStimulus(8'h99);
        applyStimulus(8'h4D);
        waitIdle();
        checkOutput("loopback_rx_count", 32'(rx_cnt - s_rx), 32'd3);
`endif

        // TX and poll raised together: TX byte goes first, poll fills after
        $display("[TB] tx with poll");
        waitIdle();
        s_rdy = ready_cnt;
        exp_mosi.push_back(8'h55);
`ifdef SPI_LOOPBACK_EN
        exp_rx.push_back(8'h55);
`endif
        iPOLL = 1'b1;
        applyStimulus(8'h55);
        repeat (100) @(posedge iCLK);
        #1;
        iPOLL = 1'b0;
        waitIdle();
        checkOutput("txpoll_ready_pulses", 32'(ready_cnt - s_rdy), 32'd1);
        checkOutput("final_mosi_queue", 32'(exp_mosi.size()), 32'd0);
        checkOutput("final_rx_queue", 32'(exp_rx.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
